rv_reg_file: RTL and testbench

- Integer register file for the RV32I core: 32 x 32-bit registers, two combinational read ports and one synchronous write port.
- Sits in the decode/writeback path.
  - Read ports feed the operand muxes.
  - Write port is driven by writeback.
- Register x0 always reads as zero.

---
 rtl/rv_reg_file.sv | 59 +++++
 tb/tb_rv_reg_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rv_reg_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational reads, one synchronous write.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module rv_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] rsW_i,
  input  logic [ADDR_WIDTH-1:0] rsR1_i,
  input  logic [ADDR_WIDTH-1:0] rsR2_i,
  input  logic [DATA_WIDTH-1:0] dataW_i,
  input  logic                  regWEn_i,
  output logic [DATA_WIDTH-1:0] dataR1_o,
  output logic [DATA_WIDTH-1:0] dataR2_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] RegArray [DEPTH];

  // x0 storage is written like any other entry; the read path masks it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        RegArray[i] <= '0;
      end
    end else if (regWEn_i) begin
      RegArray[rsW_i] <= dataW_i;
    end
  end

  // Read port 1
  always_comb begin
    dataR1_o = '0;
    if (rsR1_i != '0) begin
      dataR1_o = RegArray[rsR1_i];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (regWEn_i && (rsW_i == rsR1_i)) begin
        dataR1_o = dataW_i;
      end
`endif
    end
  end

  // Read port 2
  always_comb begin
    dataR2_o = '0;
    if (rsR2_i != '0) begin
      dataR2_o = RegArray[rsR2_i];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (regWEn_i && (rsW_i == rsR2_i)) begin
        dataR2_o = dataW_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rv_reg_file.sv
// Self-checking bench for rv_reg_file: directed cases plus randomized writes/reads
// against an array model of the architectural register state.
module tb_rv_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_w;
  logic [4:0]  rs_r1;
  logic [4:0]  rs_r2;
  logic [31:0] data_w;
  logic        reg_wen;
  logic [31:0] data_r1;
  logic [31:0] data_r2;

  logic [31:0] model [32];
  int n_checks = 0;
  int n_errors = 0;

  rv_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rsW_i    (rs_w),
    .rsR1_i   (rs_r1),
    .rsR2_i   (rs_r2),
    .dataW_i  (data_w),
    .regWEn_i (reg_wen),
    .dataR1_o (data_r1),
    .dataR2_o (data_r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One write through the port; ends at the following negedge with the entry checked
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rs_w = a;
    data_w = d;
    reg_wen = 1'b1;
    @(negedge clk);
    reg_wen = 1'b0;
    model[a] = d;
    check_eq("write_store", dut.RegArray[a], d);
  endtask

  initial begin
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] rd;
    logic [31:0] old9;

    rst_n = 1'b0;
    rs_w = '0; rs_r1 = 5'd5; rs_r2 = 5'd31;
    data_w = '0; reg_wen = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);

    // Reset state
    for (int i = 0; i < 32; i++) check_eq("reset_array", dut.RegArray[i], 32'h0);
    #1;
    check_eq("reset_r1", data_r1, 32'h0);
    check_eq("reset_r2", data_r2, 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle clears stored data at once
    write_reg(5'd5, 32'hDEADBEEF);
    rs_r1 = 5'd5;
    #1;
    check_eq("pre_reset_r1", data_r1, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_eq("async_reset_store", dut.RegArray[5], 32'h0);
    check_eq("async_reset_r1", data_r1, 32'h0);
    rs_w = 5'd6; data_w = 32'h00001234; reg_wen = 1'b1;
    @(posedge clk);
    #1;
    check_eq("write_in_reset", dut.RegArray[6], 32'h0);
    @(negedge clk);
    reg_wen = 1'b0;
    rst_n = 1'b1;

    // Basic write then read on both ports
    write_reg(5'd7, 32'h12345678);
    rs_r1 = 5'd7; rs_r2 = 5'd7;
    #1;
    check_eq("rw_r1", data_r1, 32'h12345678);
    check_eq("rw_r2", data_r2, 32'h12345678);

    // Write enable low leaves the entry untouched
    @(negedge clk);
    rs_w = 5'd3; data_w = 32'hFFFFFFFF; reg_wen = 1'b0;
    repeat (2) @(negedge clk);
    rs_r1 = 5'd3;
    #1;
    check_eq("wen_low_store", dut.RegArray[3], 32'h0);
    check_eq("wen_low_r1", data_r1, 32'h0);

    // x0 stores but always reads zero
    write_reg(5'd0, 32'hCAFEF00D);
    rs_r1 = 5'd0; rs_r2 = 5'd0;
    #1;
    check_eq("x0_r1", data_r1, 32'h0);
    check_eq("x0_r2", data_r2, 32'h0);

    // Independent ports, then swapped
    write_reg(5'd1, 32'h11111111);
    write_reg(5'd31, 32'hFFFF0000);
    rs_r1 = 5'd1; rs_r2 = 5'd31;
    #1;
    check_eq("indep_r1", data_r1, 32'h11111111);
    check_eq("indep_r2", data_r2, 32'hFFFF0000);
    rs_r1 = 5'd31; rs_r2 = 5'd1;
    #1;
    check_eq("swap_r1", data_r1, 32'hFFFF0000);
    check_eq("swap_r2", data_r2, 32'h11111111);

    // Same-cycle write and read of x9
    @(negedge clk);
    old9 = model[9];
    rs_w = 5'd9; data_w = 32'hA5A5A5A5; reg_wen = 1'b1;
    rs_r1 = 5'd9; rs_r2 = 5'd0;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check_eq("same_cycle_r1", data_r1, 32'hA5A5A5A5);
`else
    check_eq("same_cycle_r1", data_r1, old9);
`endif
    check_eq("same_cycle_x0", data_r2, 32'h0);
    @(negedge clk);
    reg_wen = 1'b0;
    model[9] = 32'hA5A5A5A5;
    #1;
    check_eq("after_edge_r1", data_r1, 32'hA5A5A5A5);

    // Random writes
    for (int i = 0; i < 200; i++) begin
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      write_reg(ra, rd);
    end

    // Random read pairs
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      rs_r1 = ra; rs_r2 = rb;
      #1;
      check_eq("rand_r1", data_r1, ref_read(ra));
      check_eq("rand_r2", data_r2, ref_read(rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
